modexp_ctrl_unit: RTL and testbench
===================================

MODEXP_CTRL_UNIT -- requirements
Module: modexp_ctrl_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the exponent width and the maximum number of square/multiply rounds; legal range 2 to 64.
REQ-002 The block SHALL have parameter MMM_CYCLES, default 10, giving the cycles per Montgomery multiplication run phase; legal range 2 to 255.
REQ-003 The block SHALL have the following ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- ena  in  1  clock enable; when low, all registers hold.
- start  in  1  request a new exponentiation; sampled in IDLE and DONE.
- abort  in  1  synchronous abort, valid in any state.
- exp_e  in  WIDTH  exponent; sampled in POST_MAP.
- clear_mmm  out  1  multiplier enable/clear-bar.
- ld_a  out  1  operand load.
- ld_r  out  1  result capture.
- lock1  out  1  register-1 update enable.
- lock2  out  1  register-2 update enable.
- sel1  out  2  operand-mux select: 00 map, 01 exponentiate, 10 remap.
- sel2  out  1  base-mux select.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE only.
- round_cnt  out  clog2(WIDTH+1)  rounds completed in the current run.

Function
REQ-004 The block SHALL implement states IDLE, PRE_MAP, MAP, POST_MAP, PRE_MMM, MMM, POST_MMM, PRE_REMAP, REMAP, POST_REMAP, DONE; all transitions SHALL occur only on clk edges with ena high.
REQ-005 IDLE SHALL go to PRE_MAP when start=1, and otherwise stay in IDLE.
REQ-006 Every PRE_x state SHALL last 1 cycle, every run state (MAP, MMM, REMAP) exactly MMM_CYCLES cycles, and every POST_x state 1 cycle, so each phase takes MMM_CYCLES+2 cycles.
REQ-007 A step counter SHALL increment in run states, clear in POST states, and end the run state when it reaches MMM_CYCLES-1.
REQ-008 Outputs in the map phase (PRE_MAP, MAP, POST_MAP) SHALL be clear_mmm=1, lock1=1, lock2=1, sel1=00 and sel2=0.
REQ-009 Outputs in the exponentiate phase (PRE_MMM, MMM, POST_MMM) SHALL be clear_mmm=1, lock1=reg_exp[0], lock2=1, sel1=01 and sel2=1.
REQ-010 Outputs in the remap phase (PRE_REMAP, REMAP, POST_REMAP) SHALL be clear_mmm=1, lock1=1, lock2=0, sel1=10 and sel2=1.
REQ-011 Within every phase, ld_a SHALL be 1 only in the PRE state and ld_r SHALL be 1 only in the POST state.
REQ-012 POST_MAP SHALL load reg_exp from exp_e, and each POST_MMM SHALL shift reg_exp right by one and increment round_cnt.
REQ-013 POST_MMM SHALL go to PRE_REMAP when round_cnt (before increment) equals WIDTH-1, and otherwise to PRE_MMM.
REQ-014 DONE SHALL drive done=1, ld_r=0 and remap-phase selects, and SHALL hold until start=1, which goes to PRE_MAP with round_cnt cleared (back-to-back runs).
REQ-015 abort=1 SHALL force IDLE on the next enabled edge from any state, clear all counters and reg_exp, and take priority over start.
REQ-016 In IDLE all outputs SHALL be 0; round_cnt SHALL hold its last value in DONE and be 0 in IDLE after reset or abort.
REQ-017 Unreachable state encodings SHALL go to IDLE.

Reset
REQ-018 While rst=1, the block SHALL be in IDLE with step counter, round counter, reg_exp and all outputs at 0, independent of clk and ena.
REQ-019 Reset asserted mid-run SHALL discard the run, and no done pulse SHALL follow.

Configuration
REQ-020 With MODEXP_CTRL_ZERO_SKIP_EN defined, POST_MMM SHALL also go to PRE_REMAP when the shifted reg_exp equals 0, so rounds executed = max(1, bit-length of exp_e).
REQ-021 With MODEXP_CTRL_ZERO_SKIP_EN undefined, exactly WIDTH rounds SHALL always execute.

Verification
REQ-022 WIDTH=8, MMM_CYCLES=10, exp_e=0xB5, start pulse -> done rises exactly 120 enabled cycles after start is sampled; round_cnt=8; lock1 during the rounds follows 1,0,1,0,1,1,0,1.
REQ-023 ZERO_SKIP_EN defined, exp_e=0x01 -> 1 round, done at cycle 36; exp_e=0x00 -> 1 round, lock1=0, done at cycle 36.
REQ-024 abort asserted in the 3rd MMM round -> IDLE next cycle, busy=0, done never asserts, then a new start completes normally.
REQ-025 ena held low for 5 cycles in the middle of REMAP -> state, counters and outputs frozen; done is delayed by exactly 5 cycles.
REQ-026 rst pulsed in the middle of a run with clk stopped -> all outputs 0 immediately; start in DONE is accepted, giving back-to-back runs with correct ld_a/ld_r pulse counts (10 each per run).

Source files
------------

// File: rtl/modexp_ctrl_unit_if.sv
// modexp_ctrl_unit_if -- control/status bundle of the modular-exponentiation
// sequencer.
//   master : drives ena, start, abort, exp_e (the requester / testbench).
//   slave  : the sequencer; drives clear_mmm, ld_a, ld_r, lock1, lock2,
//            sel1, sel2, busy, done, round_cnt.
// WIDTH must match the WIDTH of the attached modexp_ctrl_unit.
interface modexp_ctrl_unit_if #(
    parameter int WIDTH = 8
) ();
    localparam int RCW = $clog2(WIDTH + 1);

    logic             ena;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] exp_e;
    logic             clear_mmm;
    logic             ld_a;
    logic             ld_r;
    logic             lock1;
    logic             lock2;
    logic [1:0]       sel1;
    logic             sel2;
    logic             busy;
    logic             done;
    logic [RCW-1:0]   round_cnt;

    modport master (
        output ena, start, abort, exp_e,
        input  clear_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, busy, done, round_cnt
    );

    modport slave (
        input  ena, start, abort, exp_e,
        output clear_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, busy, done, round_cnt
    );
endinterface

// File: rtl/modexp_ctrl_unit.sv
// modexp_ctrl_unit -- sequencer for a right-to-left square/multiply modular
// exponentiation around a Montgomery multiplier.
// A run is: map phase, WIDTH (or fewer) exponentiate rounds, remap phase.
// Each phase is PRE (1 cycle, ld_a), RUN (MMM_CYCLES cycles), POST (1 cycle,
// ld_r), i.e. MMM_CYCLES+2 cycles.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active high
//   bus  : modexp_ctrl_unit_if.slave (ena/start/abort/exp_e in; multiplier
//          controls, busy, done, round_cnt out)
// Optional build macro MODEXP_CTRL_ZERO_SKIP_EN: stop the exponentiate rounds
// as soon as the remaining exponent bits are all zero (at least one round).
module modexp_ctrl_unit #(
    parameter int WIDTH      = 8,
    parameter int MMM_CYCLES = 10
) (
    input logic              clk,
    input logic              rst,
    modexp_ctrl_unit_if.slave bus
);
    localparam int RCW = $clog2(WIDTH + 1);
    localparam int SW  = $clog2(MMM_CYCLES + 1);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_PRE_MAP    = 4'd1;
    localparam logic [3:0] S_MAP        = 4'd2;
    localparam logic [3:0] S_POST_MAP   = 4'd3;
    localparam logic [3:0] S_PRE_MMM    = 4'd4;
    localparam logic [3:0] S_MMM        = 4'd5;
    localparam logic [3:0] S_POST_MMM   = 4'd6;
    localparam logic [3:0] S_PRE_REMAP  = 4'd7;
    localparam logic [3:0] S_REMAP      = 4'd8;
    localparam logic [3:0] S_POST_REMAP = 4'd9;
    localparam logic [3:0] S_DONE       = 4'd10;

    logic [3:0]       state, state_nxt;
    logic [SW-1:0]    step;
    logic [RCW-1:0]   round_cnt;
    logic [WIDTH-1:0] reg_exp;
    logic             step_last;
    logic             last_round;

    logic       clear_mmm, ld_a, ld_r, lock1, lock2, sel2, busy, done;
    logic [1:0] sel1;

    assign step_last = (step == SW'(MMM_CYCLES - 1));

`ifdef MODEXP_CTRL_ZERO_SKIP_EN
    // reg_exp[WIDTH-1:1] is the value reg_exp takes after this round's shift.
    assign last_round = (round_cnt == RCW'(WIDTH - 1)) || (reg_exp[WIDTH-1:1] == '0);
`else
    assign last_round = (round_cnt == RCW'(WIDTH - 1));
`endif

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE,
                S_DONE:       if (bus.start) state_nxt = S_PRE_MAP;
                S_PRE_MAP:    state_nxt = S_MAP;
                S_MAP:        if (step_last) state_nxt = S_POST_MAP;
                S_POST_MAP:   state_nxt = S_PRE_MMM;
                S_PRE_MMM:    state_nxt = S_MMM;
                S_MMM:        if (step_last) state_nxt = S_POST_MMM;
                S_POST_MMM:   state_nxt = last_round ? S_PRE_REMAP : S_PRE_MMM;
                S_PRE_REMAP:  state_nxt = S_REMAP;
                S_REMAP:      if (step_last) state_nxt = S_POST_REMAP;
                S_POST_REMAP: state_nxt = S_DONE;
                default:      state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            step      <= '0;
            round_cnt <= '0;
            reg_exp   <= '0;
        end else if (bus.ena) begin
            state <= state_nxt;
            if (bus.abort) begin
                step      <= '0;
                round_cnt <= '0;
                reg_exp   <= '0;
            end else begin
                case (state)
                    S_IDLE,
                    S_DONE: begin
                        if (bus.start) begin
                            round_cnt <= '0;
                            step      <= '0;
                        end
                    end
                    S_MAP,
                    S_MMM,
                    S_REMAP:      step <= step + 1'b1;
                    S_POST_MAP: begin
                        step    <= '0;
                        reg_exp <= bus.exp_e;
                    end
                    S_POST_MMM: begin
                        step      <= '0;
                        reg_exp   <= reg_exp >> 1;
                        round_cnt <= round_cnt + 1'b1;
                    end
                    S_POST_REMAP: step <= '0;
                    default: ;
                endcase
            end
        end
    end

    // Outputs are decoded from the state register only, so reset clears them
    // immediately without a clock.
    always_comb begin
        clear_mmm = 1'b0;
        ld_a      = 1'b0;
        ld_r      = 1'b0;
        lock1     = 1'b0;
        lock2     = 1'b0;
        sel1      = 2'b00;
        sel2      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_PRE_MAP, S_MAP, S_POST_MAP: begin
                clear_mmm = 1'b1;
                lock1     = 1'b1;
                lock2     = 1'b1;
                busy      = 1'b1;
            end
            S_PRE_MMM, S_MMM, S_POST_MMM: begin
                clear_mmm = 1'b1;
                lock1     = reg_exp[0];
                lock2     = 1'b1;
                sel1      = 2'b01;
                sel2      = 1'b1;
                busy      = 1'b1;
            end
            S_PRE_REMAP, S_REMAP, S_POST_REMAP: begin
                clear_mmm = 1'b1;
                lock1     = 1'b1;
                sel1      = 2'b10;
                sel2      = 1'b1;
                busy      = 1'b1;
            end
            S_DONE: begin
                clear_mmm = 1'b1;
                lock1     = 1'b1;
                sel1      = 2'b10;
                sel2      = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
        ld_a = (state == S_PRE_MAP) || (state == S_PRE_MMM) || (state == S_PRE_REMAP);
        ld_r = (state == S_POST_MAP) || (state == S_POST_MMM) || (state == S_POST_REMAP);
    end

    assign bus.clear_mmm = clear_mmm;
    assign bus.ld_a      = ld_a;
    assign bus.ld_r      = ld_r;
    assign bus.lock1     = lock1;
    assign bus.lock2     = lock2;
    assign bus.sel1      = sel1;
    assign bus.sel2      = sel2;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.round_cnt = round_cnt;
endmodule

// File: tb/tb_modexp_ctrl_unit.sv
// tb_modexp_ctrl_unit -- scoreboard bench for modexp_ctrl_unit.
// Each accepted start pushes the expected run (latency, rounds, lock1 bit
// pattern); a monitor sampling on the falling edge pops and compares when
// done rises. Abort and reset discard the outstanding run.
module tb_modexp_ctrl_unit;
    localparam int W     = 8;
    localparam int MC    = 10;
    localparam int PHASE = MC + 2;

    typedef struct {
        int          lat;
        int          rounds;
        logic [63:0] pat;
    } exp_t;

    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic rst    = 1'b1;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    modexp_ctrl_unit_if #(.WIDTH(W)) if_ ();

    modexp_ctrl_unit #(.WIDTH(W), .MMM_CYCLES(MC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (if_)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [9:0] out_vec();
        return {if_.clear_mmm, if_.ld_a, if_.ld_r, if_.lock1, if_.lock2,
                if_.sel1, if_.sel2, if_.busy, if_.done};
    endfunction

    function automatic int model_rounds(input logic [W-1:0] e);
        int r;
        r = W;
`ifdef MODEXP_CTRL_ZERO_SKIP_EN
        r = 1;
        for (int i = 0; i < W; i++) if (e[i]) r = i + 1;
`endif
        return r;
    endfunction

    // ---------------- monitor ----------------
    int          m_cyc, m_na, m_nr, m_rnd;
    logic [63:0] m_pat;
    bit          m_active = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                if (m_active && sb.size() > 0) e = sb.pop_front();
                m_active = 0;
            end else begin
                if (m_active) begin
                    m_cyc++;
                    if (if_.ena && if_.abort) begin
                        if (sb.size() > 0) e = sb.pop_front();
                        m_active = 0;
                    end else if (if_.ena) begin
                        if (if_.ld_a) m_na++;
                        if (if_.ld_r) m_nr++;
                        if (if_.ld_a && if_.sel1 == 2'b01) begin
                            if (m_rnd < 64) m_pat[m_rnd] = if_.lock1;
                            m_rnd++;
                        end
                        if (if_.done) begin
                            m_active = 0;
                            if (sb.size() == 0) begin
                                chk("sb_underflow", 64'd1, 64'd0);
                            end else begin
                                e = sb.pop_front();
                                chk("latency",    64'(m_cyc - 1),     64'(e.lat));
                                chk("rounds",     64'(m_rnd),         64'(e.rounds));
                                chk("round_cnt",  64'(if_.round_cnt), 64'(e.rounds));
                                chk("lock1_pat",  m_pat,              e.pat);
                                chk("ld_a_count", 64'(m_na),          64'(e.rounds + 2));
                                chk("ld_r_count", 64'(m_nr),          64'(e.rounds + 2));
                            end
                        end
                    end
                end
                if (!m_active && if_.ena && if_.start && !if_.abort && !if_.busy) begin
                    m_active = 1;
                    m_cyc = 0; m_na = 0; m_nr = 0; m_rnd = 0; m_pat = '0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] e, input int freeze);
        exp_t x;
        logic [63:0] full;
        x.rounds = model_rounds(e);
        full     = 64'(e);
        x.pat    = full & ((64'd1 << x.rounds) - 64'd1);
        x.lat    = PHASE * (x.rounds + 2) + freeze;
        sb.push_back(x);
        if_.exp_e = e;
        if_.start = 1'b1;
        tick(1);
        if_.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!if_.done && k < 3000) begin
            tick(1);
            k++;
        end
        if (!if_.done) chk(tag, 64'd0, 64'd1);
    endtask

    // Full run; optional 5-cycle ena freeze in the middle of REMAP.
    task automatic run_job(input logic [W-1:0] e, input bit freeze);
        int r;
        r = model_rounds(e);
        do_start(e, freeze ? 5 : 0);
        chk("pre_map_outs", 64'(out_vec()), 64'(10'b1101100010));
        if (freeze) begin
            tick(PHASE * (r + 1) + 5 - 1);
            if_.ena = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick(1);
                chk("frozen_remap_outs", 64'(out_vec()), 64'(10'b1001010110));
                chk("frozen_round_cnt",  64'(if_.round_cnt), 64'(r));
            end
            if_.ena = 1'b1;
        end
        wait_done("done_timeout");
        chk("done_outs", 64'({if_.done, if_.ld_r, if_.sel1, if_.sel2, if_.busy}),
            64'(6'b101010));
    endtask

    task automatic expect_no_done(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (if_.done) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        if_.ena   = 1'b1;
        if_.start = 1'b1;
        if_.abort = 1'b0;
        if_.exp_e = '0;
        #23;
        chk("reset_outs",      64'(out_vec()),      64'd0);
        chk("reset_round_cnt", 64'(if_.round_cnt), 64'd0);
        if_.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        chk("idle_outs", 64'(out_vec()), 64'd0);

        // Reference run, then back-to-back starts from DONE.
        run_job(8'hB5, 0);
        run_job(8'h01, 0);
        run_job(8'h00, 0);
        run_job(8'h80, 0);
        tick(3);
        chk("done_hold", 64'({if_.done, 4'(if_.round_cnt)}), 64'({1'b1, 4'(model_rounds(8'h80))}));

        // ena freeze inside REMAP.
        run_job(8'hB5, 1);

        // Abort in the 3rd exponentiate round (MMM run state).
        do_start(8'hB5, 0);
        tick(PHASE * 3 + 4);
        if_.abort = 1'b1;
        if_.start = 1'b1;
        tick(1);
        if_.abort = 1'b0;
        if_.start = 1'b0;
        chk("abort_outs",      64'(out_vec()),      64'd0);
        chk("abort_round_cnt", 64'(if_.round_cnt), 64'd0);
        expect_no_done("done_after_abort", 150);
        run_job(8'h3C, 0);

        // Reset with the clock stopped in the middle of a run.
        do_start(8'hC3, 0);
        tick(50);
        @(negedge clk);
        clk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outs",      64'(out_vec()),      64'd0);
        chk("async_reset_round_cnt", 64'(if_.round_cnt), 64'd0);
        #10;
        rst = 1'b0;
        #2;
        clk_en = 1'b1;
        expect_no_done("done_after_reset", 150);

        run_job(8'hFF, 0);
        run_job(8'h5A, 0);
        tick(3);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end
endmodule
